evt_snapshot_fifo: RTL and testbench
====================================

Name: evt_snapshot_fifo

Overview:
- Sits directly downstream of the two board counters and upstream of the host wire-out and trigger-in endpoints.
- Detects rising edges on the counter status flags (count1 == 0x00, count1 == 0x80, count2 == 0xFF).
- On each edge event, snapshots both counter values plus a free-running timestamp into a FIFO.
- The host drains the FIFO one entry per pop trigger, first-word-fall-through.

Parameters:
- DEPTH_LOG2, 4: FIFO depth is 2**DEPTH_LOG2 entries. Legal range 2..8.

Ports:
- sys_clk  in  1  Single clock for the block; all state on its rising edge.
- reset  in  1  Asynchronous, active-high reset.
- count1  in  8  Counter 1 value.
- count2  in  8  Counter 2 value.
- evt_in  in  3  Level flags: [0] count1eq00, [1] count1eq80, [2] count2eqFF. Synchronous to sys_clk.
- pop  in  1  Single-cycle strobe from a trigger-in bit. Advances the read pointer.
- clear  in  1  Synchronous flush: empties the FIFO, zeroes the timestamp, clears overflow.
- dout  out  32  Head entry. Valid while empty == 0.
- empty  out  1  FIFO holds no entries.
- full  out  1  FIFO holds 2**DEPTH_LOG2 entries.
- overflow  out  1  Sticky flag: an event was dropped because the FIFO was full.
- level  out  DEPTH_LOG2+1  Current entry count.

Behaviour:
- Reset (async, reset=1):
  - evt_q = 3'b000, wr_ptr = rd_ptr = 0, level = 0, ts = 0, overflow = 0.
  - Outputs: empty = 1, full = 0, dout = 0.
  - Memory contents are not reset.
- Edge detect:
  - evt_q <= evt_in every cycle.
  - rise = evt_in & ~evt_q, computed combinationally.
  - push = (rise != 0).
  - A level flag held high for many cycles yields exactly one push.
  - Because evt_q resets to 0, a flag already high when reset releases pushes once, on the first edge after release.
- Entry format: {ts[12:0], rise[2:0], count2[7:0], count1[7:0]}.
  - count1, count2 and ts are taken in the same cycle as the push.
  - Simultaneous rising edges produce ONE entry with multiple mask bits set.
- Timestamp:
  - 13-bit free-running counter, +1 every cycle.
  - Wraps 0x1FFF -> 0x0000 with no flag.
- Write: on push with !full, mem[wr_ptr] <= entry and wr_ptr <= wr_ptr+1, wrapping modulo depth.
- Read:
  - FWFT: dout = mem[rd_ptr] when !empty, else 32'h0.
  - pop with !empty: rd_ptr <= rd_ptr+1.
  - pop while empty is ignored: no pointer change, no error flag.
- Latency: an entry pushed at edge N is visible on dout and empty falls after edge N, i.e. it is readable in cycle N+1.
- Simultaneous push and pop:
  - Not full, not empty: both occur, level unchanged.
  - Full: the pop frees a slot, so the push is accepted and overflow is NOT set.
  - Empty: the pop is ignored, the push is accepted, level becomes 1.
- Full: push with full and no pop drops the entry, sets overflow = 1, and leaves pointers unchanged.
- level: +1 on accepted push only, -1 on accepted pop only. full = (level == 2**DEPTH_LOG2), empty = (level == 0).
- clear:
  - Has priority over push and pop in the same cycle.
  - Next state: pointers 0, level 0, ts 0, overflow 0.
  - evt_q still samples evt_in, so no spurious push follows clear.
- Reset mid-operation: immediate return to the reset state. A push in progress is lost.

Optional Feature:
- Macro: EVTSNAP_TIMESTAMP_EN.
- Defined: ts counter is built and fills bits [31:19] as described above.
- Undefined: no ts counter; bits [31:19] of every entry are 0. clear then affects only pointers, level and overflow. All other behaviour is identical.

Test Plan:
- Reset, then evt_in = 3'b001 held 50 cycles with count1 = 0x00, count2 = 0x12 -> exactly one entry, level = 1, dout[18:0] = {3'b001, 8'h12, 8'h00}.
- evt_in rises to 3'b101 in one cycle with count1 = 0x00, count2 = 0xFF -> one entry, dout[18:16] = 3'b101, dout[15:0] = 16'hFF00.
- DEPTH_LOG2 = 4, 17 distinct events with no pop -> full = 1, level = 16, overflow = 1. After 16 pops, entry 16 (the 17th event) never appears; empty = 1, dout = 0.
- With full = 1, event edge and pop in the same cycle -> level stays 16, overflow stays 0, last written entry = new snapshot.
- Two events 100 cycles apart (macro defined) -> dout[31:19] difference = 100 between consecutive entries. Macro undefined -> dout[31:19] = 0 for both.
- pop while empty -> no change. clear in the same cycle as an event edge with level = 5 -> level = 0, empty = 1, overflow = 0, no entry written.

Source files
------------

// File: rtl/evt_snapshot_fifo.sv
// evt_snapshot_fifo: rising-edge event detector feeding a first-word-fall-through
// snapshot FIFO. Each entry is {ts[12:0], rise[2:0], count2, count1}.
// Optional macro EVTSNAP_TIMESTAMP_EN builds the 13-bit free-running timestamp;
// without it bits [31:19] of every entry are zero.
module evt_snapshot_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic [7:0]            count1,
  input  logic [7:0]            count2,
  input  logic [2:0]            evt_in,
  input  logic                  pop,
  input  logic                  clear,
  output logic [31:0]           dout,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [2:0]            evt_q;
  logic [2:0]            rise;
  logic                  push;
  logic                  pop_ok;
  logic                  push_ok;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level_reg;
  logic                  overflow_reg;
  logic [12:0]           ts_val;
  logic [31:0]           entry;
  logic [31:0]           mem [DEPTH];

  assign rise  = evt_in & ~evt_q;
  assign push  = |rise;
  assign empty = (level_reg == '0);
  // level never exceeds DEPTH, so its top bit alone marks the full state
  assign full  = level_reg[DEPTH_LOG2];

  // clear overrides both sides; a full FIFO still takes a push when a pop frees a slot
  assign pop_ok  = pop & ~empty & ~clear;
  assign push_ok = push & (~full | pop_ok) & ~clear;

  assign entry    = {ts_val, rise, count2, count1};
  assign dout     = empty ? 32'h0 : mem[rd_ptr];
  assign level    = level_reg;
  assign overflow = overflow_reg;

`ifdef EVTSNAP_TIMESTAMP_EN
  logic [12:0] ts_reg;

  // free-running timestamp, wraps silently, zeroed by clear
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset)      ts_reg <= '0;
    else if (clear) ts_reg <= '0;
    else            ts_reg <= ts_reg + 13'd1;
  end

  assign ts_val = ts_reg;
`else
  assign ts_val = '0;
`endif

  // edge-detect history samples every cycle, including during clear
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) evt_q <= '0;
    else       evt_q <= evt_in;
  end

  // entry storage; contents are intentionally left unreset
  always_ff @(posedge sys_clk) begin
    if (push_ok) mem[wr_ptr] <= entry;
  end

  // pointers, occupancy and sticky overflow
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
      if (push & ~push_ok) overflow_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_evt_snapshot_fifo.sv
// tb_evt_snapshot_fifo: directed and randomized checks of evt_snapshot_fifo
// against a queue-based reference model. Honors EVTSNAP_TIMESTAMP_EN.
module tb_evt_snapshot_fifo;
  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;

  logic        sys_clk = 1'b0;
  logic        reset   = 1'b1;
  logic [7:0]  count1  = '0;
  logic [7:0]  count2  = '0;
  logic [2:0]  evt_in  = '0;
  logic        pop     = 1'b0;
  logic        clear   = 1'b0;
  logic [31:0] dout;
  logic        empty, full, overflow;
  logic [DL:0] level;

  evt_snapshot_fifo #(.DEPTH_LOG2(DL)) dut (
    .sys_clk(sys_clk), .reset(reset), .count1(count1), .count2(count2),
    .evt_in(evt_in), .pop(pop), .clear(clear), .dout(dout), .empty(empty),
    .full(full), .overflow(overflow), .level(level)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [31:0] q[$];
  logic [2:0]  m_prev = '0;
  logic        m_ovf  = 1'b0;
  int          m_cyc  = 0;   // edges since reset release / last clear

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".level"}, 32'(level), 32'(q.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".full"},  32'(full),  32'(q.size() == DEPTH));
    chk({tag, ".ovf"},   32'(overflow), 32'(m_ovf));
    chk({tag, ".dout"},  dout, (q.size() > 0) ? q[0] : 32'h0);
  endtask

  // one clock: drive inputs, advance model, check after the edge
  task automatic step(input logic [2:0] e, input logic [7:0] c1, input logic [7:0] c2,
                      input logic p, input logic cl, input string tag);
    logic [2:0]  r;
    logic [12:0] ts;
    logic [31:0] ent;
    evt_in = e; count1 = c1; count2 = c2; pop = p; clear = cl;
    r = e & ~m_prev;
    m_prev = e;
`ifdef EVTSNAP_TIMESTAMP_EN
    ts = 13'(m_cyc);
`else
    ts = 13'h0;
`endif
    ent = {ts, r, c2, c1};
    if (cl) begin
      q.delete();
      m_ovf = 1'b0;
      m_cyc = 0;
      $display("%s: clear", tag);
    end else begin
      if (p && q.size() > 0) begin
        void'(q.pop_front());
        $display("%s: pop", tag);
      end
      if (r != 3'b000) begin
        if (q.size() < DEPTH) begin
          q.push_back(ent);
          $display("%s: push %h", tag, ent);
        end else begin
          m_ovf = 1'b1;
          $display("%s: drop %h", tag, ent);
        end
      end
      m_cyc = (m_cyc + 1) % 8192;
    end
    @(posedge sys_clk); #1;
    chk_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(3'b000, 8'h00, 8'h00, 1'b0, 1'b0, tag);
  endtask

  // n events on flag 0 with random counts, each followed by a low cycle
  task automatic events(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(3'b001, 8'($urandom), 8'($urandom), 1'b0, 1'b0, tag);
      step(3'b000, 8'h00, 8'h00, 1'b0, 1'b0, tag);
    end
  endtask

  task automatic pops(input int n, input string tag);
    for (int i = 0; i < n; i++) step(3'b000, 8'h00, 8'h00, 1'b1, 1'b0, tag);
  endtask

  task automatic model_reset();
    q.delete();
    m_prev = '0;
    m_ovf  = 1'b0;
    m_cyc  = 0;
  endtask

  logic [12:0] ts_a, ts_b;

  initial begin
    // reset state
    repeat (3) @(posedge sys_clk);
    #1;
    chk_all("reset");
    reset = 1'b0;
    model_reset();

    // held level flag yields exactly one push
    for (int i = 0; i < 50; i++) step(3'b001, 8'h00, 8'h12, 1'b0, 1'b0, "hold");
    chk("hold.level1", 32'(level), 32'd1);
    chk("hold.low19", 32'(dout[18:0]), 32'({3'b001, 8'h12, 8'h00}));

    // simultaneous edges form one entry
    step(3'b000, 8'h00, 8'h00, 1'b1, 1'b0, "multi");
    step(3'b101, 8'h00, 8'hFF, 1'b0, 1'b0, "multi");
    chk("multi.mask", 32'(dout[18:16]), 32'(3'b101));
    chk("multi.cnt", 32'(dout[15:0]), 32'h0000FF00);
    chk("multi.level", 32'(level), 32'd1);

    // 17 events into a 16-deep FIFO, then drain
    step(3'b000, 8'h00, 8'h00, 1'b0, 1'b1, "clr");
    events(17, "fill17");
    chk("fill17.full", 32'(full), 32'd1);
    chk("fill17.level", 32'(level), 32'd16);
    chk("fill17.ovf", 32'(overflow), 32'd1);
    pops(16, "drain");
    chk("drain.empty", 32'(empty), 32'd1);
    chk("drain.dout", dout, 32'h0);

    // full with simultaneous edge and pop: accepted, no overflow
    step(3'b000, 8'h00, 8'h00, 1'b0, 1'b1, "clr");
    events(16, "fill16");
    step(3'b001, 8'hAA, 8'h55, 1'b1, 1'b0, "fullpp");
    chk("fullpp.level", 32'(level), 32'd16);
    chk("fullpp.ovf", 32'(overflow), 32'd0);
    pops(15, "drain");
    chk("fullpp.last", 32'(dout[18:0]), 32'({3'b001, 8'h55, 8'hAA}));
    pops(1, "drain");

    // two events 100 cycles apart
    step(3'b000, 8'h00, 8'h00, 1'b0, 1'b1, "clr");
    step(3'b010, 8'h80, 8'h01, 1'b0, 1'b0, "ts");
    idle(99, "ts");
    step(3'b010, 8'h80, 8'h02, 1'b0, 1'b0, "ts");
    ts_a = dout[31:19];
    pops(1, "ts");
    ts_b = dout[31:19];
`ifdef EVTSNAP_TIMESTAMP_EN
    chk("ts.diff", 32'(ts_b - ts_a), 32'd100);
`else
    chk("ts.a0", 32'(ts_a), 32'd0);
    chk("ts.b0", 32'(ts_b), 32'd0);
`endif
    pops(1, "ts");

    // pop while empty is ignored
    pops(3, "popempty");

    // clear with a simultaneous edge at level 5 with overflow set
    events(17, "fill17b");
    pops(11, "to5");
    chk("to5.level", 32'(level), 32'd5);
    step(3'b001, 8'h33, 8'h44, 1'b0, 1'b1, "clrevt");
    chk("clrevt.level", 32'(level), 32'd0);
    chk("clrevt.ovf", 32'(overflow), 32'd0);
    step(3'b001, 8'h33, 8'h44, 1'b0, 1'b0, "clrevt.hold");
    chk("clrevt.nopush", 32'(empty), 32'd1);

    // randomized traffic with rare clears
    for (int i = 0; i < 400; i++) begin
      step(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 60) == 0), "rand");
    end

    // asynchronous reset mid-operation
    events(4, "prereset");
    step(3'b001, 8'h11, 8'h22, 1'b0, 1'b0, "prereset");
    reset = 1'b1;
    #1;
    model_reset();
    chk_all("asyncrst");
    @(posedge sys_clk); #1;
    reset = 1'b0;
    // flag already high at release pushes once on the first edge
    step(3'b001, 8'h01, 8'h02, 1'b0, 1'b0, "postrst");
    step(3'b001, 8'h01, 8'h02, 1'b0, 1'b0, "postrst");
    chk("postrst.level", 32'(level), 32'd1);
    for (int i = 0; i < 200; i++) begin
      step(3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
           1'b0, "rand2");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
